sequence_recorder: RTL and testbench

SEQUENCE_RECORDER -- requirements
Module: sequence_recorder

---
 rtl/sequence_recorder.sv | 172 +++++++++++++++++
 tb/tb_sequence_recorder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_recorder.sv
// sequence_recorder: records short streams of WORD_SIZE-bit steps into a
// MEMORY_QTY-deep register array and plays them back one entry per step pulse,
// either looping or as a one-shot that parks in HALT at the last entry.
// The display output is a registered copy of the addressed entry (1-cycle lag).
// Optional feature: define SEQUENCE_RECORDER_PINGPONG_EN to make looped
// playback bounce between the first and last entries instead of wrapping.
// "sequence" is a reserved word in SystemVerilog, so the record word port is
// named sequence_i. state_o exposes the FSM state for observation.
module sequence_recorder #(
  parameter int WORD_SIZE = 2,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY = 16,
  parameter logic [WORD_SIZE-1:0] WORD_INIT = 2'b10
) (
  input  logic                    clock,
  input  logic                    Reset,
  input  logic                    step,
  input  logic                    store,
  input  logic [WORD_SIZE-1:0]    sequence_i,
  input  logic                    clear,
  input  logic                    loop,
  output logic [WORD_SIZE-1:0]    display,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic [ADDRESS_SIZE:0]   length,
  output logic                    full,
  output logic                    halted,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PLAY  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [ADDRESS_SIZE:0] QTY_L   = (ADDRESS_SIZE+1)'(MEMORY_QTY);
  localparam logic [ADDRESS_SIZE:0] LEN_ONE = (ADDRESS_SIZE+1)'(1);

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE:0]   length_q, length_d;
  logic [ADDRESS_SIZE-1:0] r_addr_q, r_addr_d;
  logic [WORD_SIZE-1:0]    display_q, display_d;
  logic                    loop_q;
  logic [WORD_SIZE-1:0]    mem_q [MEMORY_QTY];

  logic store_ok;
  logic at_end;
  logic loop_rise;

  // A store is only accepted while there is room; the end-of-sequence test
  // always uses the length held before any store in the same cycle.
  assign store_ok  = store && (length_q != QTY_L);
  assign at_end    = ({1'b0, r_addr_q} == (length_q - LEN_ONE));
  assign loop_rise = loop && !loop_q;

`ifdef SEQUENCE_RECORDER_PINGPONG_EN
  logic dir_q, dir_d;   // 1 = counting up, 0 = counting down

  // Bounce direction register.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) dir_q <= 1'b1;
    else        dir_q <= dir_d;
  end
`endif

  // Next-state logic: clear wins over everything, then store and step.
  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    r_addr_d  = r_addr_q;
`ifdef SEQUENCE_RECORDER_PINGPONG_EN
    dir_d     = dir_q;
`endif
    if (clear) begin
      state_d  = S_EMPTY;
      length_d = '0;
      r_addr_d = '0;
`ifdef SEQUENCE_RECORDER_PINGPONG_EN
      dir_d    = 1'b1;
`endif
    end else begin
      if (store_ok) length_d = length_q + LEN_ONE;
      case (state_q)
        S_EMPTY: begin
          r_addr_d = '0;
          if (store_ok) begin
            state_d = S_PLAY;
`ifdef SEQUENCE_RECORDER_PINGPONG_EN
            dir_d   = 1'b1;
`endif
          end
        end
        S_PLAY: begin
          if (step) begin
`ifdef SEQUENCE_RECORDER_PINGPONG_EN
            if (loop) begin
              if (length_q == LEN_ONE) begin
                r_addr_d = '0;
              end else if (dir_q) begin
                if (!at_end) begin
                  r_addr_d = r_addr_q + 1'b1;
                end else begin
                  r_addr_d = r_addr_q - 1'b1;
                  dir_d    = 1'b0;
                end
              end else begin
                if (r_addr_q != '0) begin
                  r_addr_d = r_addr_q - 1'b1;
                end else begin
                  r_addr_d = r_addr_q + 1'b1;
                  dir_d    = 1'b1;
                end
              end
            end else begin
              if (!at_end) r_addr_d = r_addr_q + 1'b1;
              else         state_d  = S_HALT;
            end
`else
            if (!at_end)   r_addr_d = r_addr_q + 1'b1;
            else if (loop) r_addr_d = '0;
            else           state_d  = S_HALT;
`endif
          end
        end
        S_HALT: begin
          if (store_ok || loop_rise) state_d = S_PLAY;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Display source: the init word while empty or clearing, else the entry.
  always_comb begin
    display_d = mem_q[r_addr_q];
    if (clear || (state_q == S_EMPTY)) display_d = WORD_INIT;
  end

  // Control registers.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_EMPTY;
      length_q  <= '0;
      r_addr_q  <= '0;
      display_q <= WORD_INIT;
      loop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      r_addr_q  <= r_addr_d;
      display_q <= display_d;
      loop_q    <= loop;
    end
  end

  // Step memory: written at the entry just past the recording; clear leaves it.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < MEMORY_QTY; i++) mem_q[i] <= WORD_INIT;
    end else if (!clear && store_ok) begin
      mem_q[length_q[ADDRESS_SIZE-1:0]] <= sequence_i;
    end
  end

  assign display = display_q;
  assign r_addr  = r_addr_q;
  assign length  = length_q;
  assign full    = (length_q == QTY_L);
  assign halted  = (state_q == S_HALT);
  assign state_o = state_q;

endmodule

// File: tb/tb_sequence_recorder.sv
// tb_sequence_recorder: table-driven vectors plus hand-written sequences for
// sequence_recorder. Each driven cycle pushes its expected outputs to exp_q;
// the entry is popped and compared one clock later.
// Expected word packing: {chk, chk_disp, r_addr[3:0], length[4:0], halted, full, display[1:0]}
module tb_sequence_recorder;

  localparam int W = 15;

  logic       clk, rst_n;
  logic       in_step, in_store, in_clear, in_loop;
  logic [1:0] in_seq;
  logic [1:0] display;
  logic [3:0] r_addr;
  logic [4:0] length;
  logic       full, halted;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  typedef struct {
    logic       st, sto;
    logic [1:0] sq;
    logic       clr, lp;
    int         r, len;
    logic       h;
    logic [1:0] d;
  } vec_t;

  vec_t tv[36];
  logic [1:0] w[17];

  sequence_recorder dut (
    .clock(clk), .Reset(rst_n), .step(in_step), .store(in_store),
    .sequence_i(in_seq), .clear(in_clear), .loop(in_loop),
    .display(display), .r_addr(r_addr), .length(length),
    .full(full), .halted(halted), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic st, sto, input logic [1:0] sq,
                              input logic clr, lp, input int r, len,
                              input logic h, input logic [1:0] d);
    vec_t v;
    v.st = st; v.sto = sto; v.sq = sq; v.clr = clr; v.lp = lp;
    v.r = r; v.len = len; v.h = h; v.d = d;
    return v;
  endfunction

  function automatic logic [W-1:0] ex(input logic cd, input int r, len,
                                      input logic h, input logic [1:0] d);
    logic [3:0] r4;
    logic [4:0] l5;
    r4 = r[3:0];
    l5 = len[4:0];
    return {1'b1, cd, r4, l5, h, (len == 16), d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // scoreboard: pop one expectation and compare against the outputs
  task automatic check_pending();
    logic [W-1:0] e;
    logic [12:0]  act;
    string        nm;
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    act = {r_addr, length, halted, full, display};
    if (e[14]) begin
      if (e[13]) chk(nm, {19'd0, act}, {19'd0, e[12:0]});
      else       chk(nm, {21'd0, act[12:2]}, {21'd0, e[12:2]});
    end
  endtask

  // driver: compare the previous cycle, then drive this one
  task automatic cycle(input logic st, sto, input logic [1:0] sq,
                       input logic clr, lp, input logic [W-1:0] e, input string nm);
    @(negedge clk);
    check_pending();
    in_step = st; in_store = sto; in_seq = sq; in_clear = clr; in_loop = lp;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
    in_step = 1'b0; in_store = 1'b0; in_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_step = 1'b0; in_store = 1'b0; in_seq = 2'b00; in_clear = 1'b0; in_loop = 1'b0;

    // table: REQ-033 looped, REQ-034 one-shot, length-1, store+step
    tv[0]  = mk(0,1,2'b01,0,1, 0,1,0,2'b10);
    tv[1]  = mk(0,1,2'b11,0,1, 0,2,0,2'b01);
    tv[2]  = mk(0,1,2'b00,0,1, 0,3,0,2'b01);
    tv[3]  = mk(0,0,2'b00,0,1, 0,3,0,2'b01);
    tv[4]  = mk(1,0,2'b00,0,1, 1,3,0,2'b01);
    tv[5]  = mk(1,0,2'b00,0,1, 2,3,0,2'b11);
`ifdef SEQUENCE_RECORDER_PINGPONG_EN
    tv[6]  = mk(1,0,2'b00,0,1, 1,3,0,2'b00);
    tv[7]  = mk(1,0,2'b00,0,1, 0,3,0,2'b11);
    tv[8]  = mk(0,0,2'b00,0,1, 0,3,0,2'b01);
`else
    tv[6]  = mk(1,0,2'b00,0,1, 0,3,0,2'b00);
    tv[7]  = mk(1,0,2'b00,0,1, 1,3,0,2'b01);
    tv[8]  = mk(0,0,2'b00,0,1, 1,3,0,2'b11);
`endif
    tv[9]  = mk(0,0,2'b00,1,1, 0,0,0,2'b10);
    tv[10] = mk(0,1,2'b01,0,0, 0,1,0,2'b10);
    tv[11] = mk(0,1,2'b11,0,0, 0,2,0,2'b01);
    tv[12] = mk(0,1,2'b00,0,0, 0,3,0,2'b01);
    tv[13] = mk(1,0,2'b00,0,0, 1,3,0,2'b01);
    tv[14] = mk(1,0,2'b00,0,0, 2,3,0,2'b11);
    tv[15] = mk(1,0,2'b00,0,0, 2,3,1,2'b00);
    tv[16] = mk(1,0,2'b00,0,0, 2,3,1,2'b00);
    tv[17] = mk(0,1,2'b10,0,0, 2,4,0,2'b00);
    tv[18] = mk(1,0,2'b00,0,0, 3,4,0,2'b00);
    tv[19] = mk(0,0,2'b00,0,0, 3,4,0,2'b10);
    tv[20] = mk(1,0,2'b00,0,0, 3,4,1,2'b10);
    tv[21] = mk(0,0,2'b00,0,1, 3,4,0,2'b10);
`ifdef SEQUENCE_RECORDER_PINGPONG_EN
    tv[22] = mk(1,0,2'b00,0,1, 2,4,0,2'b10);
    tv[23] = mk(0,0,2'b00,0,1, 2,4,0,2'b00);
`else
    tv[22] = mk(1,0,2'b00,0,1, 0,4,0,2'b10);
    tv[23] = mk(0,0,2'b00,0,1, 0,4,0,2'b01);
`endif
    tv[24] = mk(0,0,2'b00,1,0, 0,0,0,2'b10);
    tv[25] = mk(1,0,2'b00,0,0, 0,0,0,2'b10);
    tv[26] = mk(0,1,2'b11,0,0, 0,1,0,2'b10);
    tv[27] = mk(1,0,2'b00,0,1, 0,1,0,2'b11);
    tv[28] = mk(1,0,2'b00,0,0, 0,1,1,2'b11);
    tv[29] = mk(1,1,2'b01,0,0, 0,2,0,2'b11);
    tv[30] = mk(1,1,2'b10,0,0, 1,3,0,2'b11);
    tv[31] = mk(1,1,2'b00,0,0, 2,4,0,2'b01);
    tv[32] = mk(1,1,2'b11,0,0, 3,5,0,2'b10);
    tv[33] = mk(1,0,2'b00,0,0, 4,5,0,2'b00);
    tv[34] = mk(1,1,2'b01,0,0, 4,6,1,2'b11);
    tv[35] = mk(0,0,2'b00,0,0, 4,6,1,2'b11);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_display", {30'd0, display}, 32'h2);
    chk("rst_length",  {27'd0, length},  32'h0);
    chk("rst_r_addr",  {28'd0, r_addr},  32'h0);
    chk("rst_halted",  {31'd0, halted},  32'h0);
    chk("rst_full",    {31'd0, full},    32'h0);
    chk("rst_state",   {30'd0, state_o}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 36; i++)
      cycle(tv[i].st, tv[i].sto, tv[i].sq, tv[i].clr, tv[i].lp,
            ex(1'b1, tv[i].r, tv[i].len, tv[i].h, tv[i].d), $sformatf("vec%0d", i));
    flush();

    // 17 stores: capacity limit, full flag, 17th word dropped
    cycle(0,0,2'b00,1,1, ex(1'b1,0,0,0,2'b10), "fill_clear");
    for (int i = 0; i < 17; i++) w[i] = 2'($urandom_range(0, 3));
    w[16] = ~w[0];
    for (int i = 0; i < 17; i++)
      cycle(0,1,w[i],0,1, ex(1'b0,0,(i < 16) ? i+1 : 16,0,2'b00), $sformatf("fill_store%0d", i));
    cycle(0,0,2'b00,0,1, ex(1'b1,0,16,0,w[0]), "fill_idle");
    for (int k = 1; k < 16; k++)
      cycle(1,0,2'b00,0,1, ex(1'b1,k,16,0,w[k-1]), $sformatf("fill_play%0d", k));
    cycle(0,0,2'b00,0,1, ex(1'b1,15,16,0,w[15]), "fill_last");
    cycle(1,0,2'b00,0,1, ex(1'b1,0,16,0,w[15]), "fill_wrap");
    cycle(0,0,2'b00,0,1, ex(1'b1,0,16,0,w[0]), "fill_entry0");
    cycle(1,0,2'b00,0,1, ex(1'b1,1,16,0,w[0]), "fill_step");
    flush();

    // asynchronous reset in the middle of playback
    #2 rst_n = 1'b0;
    #1;
    chk("arst_display", {30'd0, display}, 32'h2);
    chk("arst_length",  {27'd0, length},  32'h0);
    chk("arst_r_addr",  {28'd0, r_addr},  32'h0);
    chk("arst_halted",  {31'd0, halted},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0,1,2'b01,0,0, ex(1'b1,0,1,0,2'b10), "resume_store");
    cycle(0,0,2'b00,0,0, ex(1'b1,0,1,0,2'b01), "resume_disp");

    // clear beats simultaneous store and step at length 5
    for (int i = 1; i < 5; i++)
      cycle(0,1,2'b11,0,0, ex(1'b0,0,i+1,0,2'b00), $sformatf("cs_store%0d", i));
    cycle(1,1,2'b01,1,0, ex(1'b1,0,0,0,2'b10), "cs_clear");
    flush();
    chk("cs_state", {30'd0, state_o}, 32'h0);
    cycle(1,0,2'b00,0,0, ex(1'b1,0,0,0,2'b10), "cs_idle");

`ifdef SEQUENCE_RECORDER_PINGPONG_EN
    // bounce playback over three entries
    cycle(0,0,2'b00,1,1, ex(1'b1,0,0,0,2'b10), "pp_clear");
    cycle(0,1,2'b01,0,1, ex(1'b0,0,1,0,2'b00), "pp_s0");
    cycle(0,1,2'b11,0,1, ex(1'b0,0,2,0,2'b00), "pp_s1");
    cycle(0,1,2'b00,0,1, ex(1'b0,0,3,0,2'b00), "pp_s2");
    cycle(1,0,2'b00,0,1, ex(1'b0,1,3,0,2'b00), "pp_r1");
    cycle(1,0,2'b00,0,1, ex(1'b0,2,3,0,2'b00), "pp_r2");
    cycle(1,0,2'b00,0,1, ex(1'b0,1,3,0,2'b00), "pp_r3");
    cycle(1,0,2'b00,0,1, ex(1'b0,0,3,0,2'b00), "pp_r4");
    cycle(1,0,2'b00,0,1, ex(1'b0,1,3,0,2'b00), "pp_r5");
    cycle(1,0,2'b00,0,1, ex(1'b0,2,3,0,2'b00), "pp_r6");
`endif
    flush();
    flush();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
